// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: two-port round-robin arbiter and sequencer in front of one
// 64 x 20-bit word store (mem_bank_64).
//
// After reset the block zero-fills every word of the bank, one word per cycle.
// It then grants at most one request per cycle to port A (instruction side) or
// port B (data side). A granted op is registered into an issue stage, driven to
// the bank during the next cycle, and its result is returned with an rvalid pulse
// two cycles after the grant.
//
// Ports:
//   clk, rst_n           system clock; synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A request (held stable until granted)
//   a_gnt                port A request accepted this cycle (combinational)
//   a_rvalid/a_rdata/a_rerr      port A response (1-cycle pulse, data held)
//   b_*                  same set of signals for port B
//   init_busy            high while the zero-fill sweep runs
//   err_sticky           set by any bank err on a RUN access, cleared by reset
//   mem_WE/mem_in/mem_addr       bank controls
//   mem_out/mem_err      bank read data and error flag (combinational on addr)
module mem_bank_arbiter #(
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rerr,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rerr,

    output logic              init_busy,
    output logic              err_sticky,

    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_err
);

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // rr_q = 0 prefers port A on a tie, 1 prefers port B.
    logic              rr_q, rr_d;

    // Issue stage: the op granted in the previous cycle.
    logic              iss_valid_q, iss_valid_d;
    logic              iss_we_q, iss_we_d;
    logic              iss_port_q, iss_port_d;  // 0 = A, 1 = B
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;

    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_rerr_q, b_rerr_q;
    logic              err_sticky_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        iss_valid_d = 1'b0;
        iss_we_d    = iss_we_q;
        iss_port_d  = iss_port_q;
        iss_addr_d  = iss_addr_q;
        iss_wdata_d = iss_wdata_q;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;

        unique case (state_q)
            StInit: begin
                cnt_d       = cnt_q + ADDR_W'(1);
                // Track the sweep address so the bank address holds its last
                // value once the sweep hands over to normal operation.
                iss_we_d    = 1'b0;
                iss_addr_d  = cnt_q;
                iss_wdata_d = '0;
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_gnt = a_req && (!b_req || !rr_q);
                b_gnt = b_req && (!a_req || rr_q);
                if (a_gnt) begin
                    iss_valid_d = 1'b1;
                    iss_we_d    = a_we;
                    iss_port_d  = 1'b0;
                    iss_addr_d  = a_addr;
                    iss_wdata_d = a_wdata;
                    rr_d        = 1'b1;
                end else if (b_gnt) begin
                    iss_valid_d = 1'b1;
                    iss_we_d    = b_we;
                    iss_port_d  = 1'b1;
                    iss_addr_d  = b_addr;
                    iss_wdata_d = b_wdata;
                    rr_d        = 1'b0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            iss_valid_q  <= 1'b0;
            iss_we_q     <= 1'b0;
            iss_port_q   <= 1'b0;
            iss_addr_q   <= '0;
            iss_wdata_q  <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_rerr_q     <= 1'b0;
            b_rerr_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            iss_valid_q <= iss_valid_d;
            iss_we_q    <= iss_we_d;
            iss_port_q  <= iss_port_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;

            // Bank output is valid while the issued op drives the address.
            a_rvalid_q <= iss_valid_q && !iss_port_q;
            b_rvalid_q <= iss_valid_q && iss_port_q;
            if (iss_valid_q && !iss_port_q) begin
                a_rdata_q <= mem_out;
                a_rerr_q  <= mem_err;
            end
            if (iss_valid_q && iss_port_q) begin
                b_rdata_q <= mem_out;
                b_rerr_q  <= mem_err;
            end
            // iss_valid_q is never set during the sweep, so INIT errors are ignored.
            err_sticky_q <= err_sticky_q || (iss_valid_q && mem_err);
        end
    end

    assign init_busy  = (state_q == StInit);
    // Gate the sweep write with rst_n so the bank is never written while reset is held.
    assign mem_WE     = init_busy ? rst_n : (iss_valid_q && iss_we_q);
    assign mem_addr   = init_busy ? cnt_q : iss_addr_q;
    assign mem_in     = init_busy ? '0 : iss_wdata_q;

    assign a_rvalid   = a_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign a_rerr     = a_rerr_q;
    assign b_rvalid   = b_rvalid_q;
    assign b_rdata    = b_rdata_q;
    assign b_rerr     = b_rerr_q;
    assign err_sticky = err_sticky_q;

endmodule
